// File: rtl/processor_pkg.sv
// Shared FSM state encoding and Z80 opcode constants for the processor core.
package processor_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_OPCODE,
        S_LO_A,
        S_LO_D,
        S_HI_A,
        S_HI_D,
        S_MEM_A,
        S_MEM_D,
        S_WRITE,
        S_HALTED
    } state_t;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_INC_A  = 8'h3C;
    localparam logic [7:0] OP_LD_AB  = 8'h78;
    localparam logic [7:0] OP_LD_BA  = 8'h47;
    localparam logic [7:0] OP_LD_AN  = 8'h3E;
    localparam logic [7:0] OP_LD_BN  = 8'h06;
    localparam logic [7:0] OP_ADD_AN = 8'hC6;
    localparam logic [7:0] OP_JP     = 8'hC3;
    localparam logic [7:0] OP_JP_Z   = 8'hCA;
    localparam logic [7:0] OP_JP_NZ  = 8'hC2;
    localparam logic [7:0] OP_LD_AM  = 8'h3A;
    localparam logic [7:0] OP_LD_MA  = 8'h32;
    localparam logic [7:0] OP_HALT   = 8'h76;

endpackage

// File: rtl/processor_alu.sv
// 8-bit adder shared by ADD A,n and INC A; produces result, zero and carry.
module processor_alu (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_inc,
    output logic [7:0] o_res,
    output logic       o_z,
    output logic       o_c
);

    logic [8:0] w_sum;

    always_comb begin
        w_sum = {1'b0, i_a} + {1'b0, (i_inc ? 8'h01 : i_b)};
        o_res = w_sum[7:0];
        o_c   = w_sum[8];
        o_z   = (w_sum[7:0] == 8'h00);
    end

endmodule

// File: rtl/processor.sv
// Multi-cycle 8-bit core running a small Z80 subset over a synchronous-read RAM.
module processor
    import processor_pkg::*;
(
    input  logic        clk,
    input  logic        locked,
    input  logic        m_ready,
    output logic [15:0] o_addr,
    input  logic [7:0]  i_data,
    output logic [7:0]  o_data,
    output logic        o_wr
);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_pc, w_pc_nxt;
    logic [7:0]  r_a, w_a_nxt;
    logic [7:0]  r_b, w_b_nxt;
    logic [7:0]  r_ir, w_ir_nxt;
    logic [15:0] r_tmp, w_tmp_nxt;
    logic        r_z, w_z_nxt;
    logic        r_c, w_c_nxt;
    logic        r_halt, w_halt_nxt;
    logic [15:0] r_addr, w_addr_nxt;
    logic [7:0]  r_data, w_data_nxt;
    logic        r_wr, w_wr_nxt;

    logic [7:0]  w_alu_res;
    logic        w_alu_z, w_alu_c, w_alu_inc;

    assign w_alu_inc = (r_state == S_OPCODE);

    processor_alu u_alu (
        .i_a   (r_a),
        .i_b   (i_data),
        .i_inc (w_alu_inc),
        .o_res (w_alu_res),
        .o_z   (w_alu_z),
        .o_c   (w_alu_c)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_ir_nxt    = r_ir;
        w_tmp_nxt   = r_tmp;
        w_z_nxt     = r_z;
        w_c_nxt     = r_c;
        w_halt_nxt  = r_halt;

        case (r_state)
            S_FETCH: w_state_nxt = S_OPCODE;
            S_OPCODE: begin
                // Decode straight from the read data; IR is only needed by later states.
                w_ir_nxt    = i_data;
                w_pc_nxt    = r_pc + 16'd1;
                w_state_nxt = S_FETCH;
                case (i_data)
                    OP_NOP:   w_state_nxt = S_FETCH;
                    OP_INC_A: begin
                        w_a_nxt = w_alu_res;
                        w_z_nxt = w_alu_z;
                    end
                    OP_LD_AB: w_a_nxt = r_b;
                    OP_LD_BA: w_b_nxt = r_a;
                    OP_HALT: begin
                        w_halt_nxt  = 1'b1;
                        w_state_nxt = S_HALTED;
                    end
                    OP_LD_AN, OP_LD_BN, OP_ADD_AN, OP_JP, OP_JP_Z,
                    OP_JP_NZ, OP_LD_AM, OP_LD_MA: w_state_nxt = S_LO_A;
                    default:  w_state_nxt = S_FETCH;
                endcase
            end
            S_LO_A: w_state_nxt = S_LO_D;
            S_LO_D: begin
                w_pc_nxt    = r_pc + 16'd1;
                w_state_nxt = S_FETCH;
                case (r_ir)
                    OP_LD_AN:  w_a_nxt = i_data;
                    OP_LD_BN:  w_b_nxt = i_data;
                    OP_ADD_AN: begin
                        w_a_nxt = w_alu_res;
                        w_z_nxt = w_alu_z;
                        w_c_nxt = w_alu_c;
                    end
                    default: begin
                        w_tmp_nxt[7:0] = i_data;
                        w_state_nxt    = S_HI_A;
                    end
                endcase
            end
            S_HI_A: w_state_nxt = S_HI_D;
            S_HI_D: begin
                w_pc_nxt        = r_pc + 16'd1;
                w_tmp_nxt[15:8] = i_data;
                w_state_nxt     = S_FETCH;
                case (r_ir)
                    OP_JP:    w_pc_nxt = {i_data, r_tmp[7:0]};
                    OP_JP_Z:  if (r_z)  w_pc_nxt = {i_data, r_tmp[7:0]};
                    OP_JP_NZ: if (!r_z) w_pc_nxt = {i_data, r_tmp[7:0]};
                    OP_LD_AM: w_state_nxt = S_MEM_A;
                    OP_LD_MA: w_state_nxt = S_WRITE;
                    default:  w_state_nxt = S_FETCH;
                endcase
            end
            S_MEM_A: w_state_nxt = S_MEM_D;
            S_MEM_D: begin
                w_a_nxt     = i_data;
                w_state_nxt = S_FETCH;
            end
            S_WRITE:  w_state_nxt = S_FETCH;
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_FETCH;
        endcase

        if (r_halt) w_state_nxt = S_HALTED;

        // Outputs are registered, so they are derived from the state being entered.
        if (w_state_nxt inside {S_MEM_A, S_MEM_D, S_WRITE}) w_addr_nxt = w_tmp_nxt;
        else                                                w_addr_nxt = w_pc_nxt;
        w_wr_nxt   = (w_state_nxt == S_WRITE);
        w_data_nxt = w_wr_nxt ? w_a_nxt : r_data;
    end

    always_ff @(posedge clk) begin
        if (!locked) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_ir    <= '0;
            r_tmp   <= '0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            r_halt  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_wr    <= 1'b0;
        end else if (m_ready) begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_ir    <= w_ir_nxt;
            r_tmp   <= w_tmp_nxt;
            r_z     <= w_z_nxt;
            r_c     <= w_c_nxt;
            r_halt  <= w_halt_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_wr    <= w_wr_nxt;
        end
    end

    assign o_addr = r_addr;
    assign o_data = r_data;
    assign o_wr   = r_wr;

endmodule

// File: tb/tb_processor.sv
// Scoreboard bench: an instruction-level interpreter predicts writes, cycle count and final state.
module tb_processor;

    logic        clk = 1'b0;
    logic        locked, m_ready;
    logic [15:0] o_addr;
    logic [7:0]  i_data, o_data;
    logic        o_wr;

    processor dut (
        .clk     (clk),
        .locked  (locked),
        .m_ready (m_ready),
        .o_addr  (o_addr),
        .i_data  (i_data),
        .o_data  (o_data),
        .o_wr    (o_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic [7:0]  prog    [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [7:0]  wmem    [0:65535];
    logic        wvalid  [0:65535];
    logic [15:0] trace   [0:255];
    wr_t         exp_q[$];

    int          checks = 0, failures = 0;
    int          act_cyc, wcnt, m_cyc;
    logic        halted_seen, mon_en;
    logic [15:0] m_pc;
    logic [7:0]  m_a, m_b;
    logic        m_z, m_c;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    // Synchronous-read RAM: program image overlaid by bytes written while running.
    initial forever begin
        @(posedge clk);
        if (!locked) begin
            for (int i = 0; i < 65536; i++) wvalid[i] = 1'b0;
        end else if (o_wr && m_ready) begin
            wmem[o_addr]   = o_data;
            wvalid[o_addr] = 1'b1;
        end
        i_data <= wvalid[o_addr] ? wmem[o_addr] : prog[o_addr];
    end

    // Monitor: counts active cycles and retires writes against the scoreboard.
    initial forever begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            if (dut.r_halt) halted_seen = 1'b1;
            else if (locked && m_ready) begin
                if (act_cyc < 256) trace[act_cyc] = o_addr;
                act_cyc++;
                if (o_wr) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual=%0h:%0h required=none", o_addr, o_data);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        chk("wr_addr", o_addr, e.a);
                        chk("wr_data", o_data, e.d);
                    end
                end
            end
        end
    end

    task automatic model_run();
        logic [15:0] pc, nn;
        logic [7:0]  op, a, b, n;
        logic [8:0]  s;
        logic        z, c, done;
        int          cyc;
        pc = '0; a = '0; b = '0; z = 1'b0; c = 1'b0; cyc = 0; done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            op = ref_mem[pc];
            pc = pc + 16'd1;
            case (op)
                8'h3C: begin a = a + 8'd1; z = (a == 8'h00); cyc += 2; end
                8'h78: begin a = b; cyc += 2; end
                8'h47: begin b = a; cyc += 2; end
                8'h76: begin done = 1'b1; cyc += 2; end
                8'h3E, 8'h06, 8'hC6: begin
                    n = ref_mem[pc];
                    pc = pc + 16'd1;
                    cyc += 4;
                    if (op == 8'h3E) a = n;
                    else if (op == 8'h06) b = n;
                    else begin
                        s = {1'b0, a} + {1'b0, n};
                        a = s[7:0]; c = s[8]; z = (a == 8'h00);
                    end
                end
                8'hC3, 8'hCA, 8'hC2, 8'h3A, 8'h32: begin
                    nn = {ref_mem[pc + 16'd1], ref_mem[pc]};
                    pc = pc + 16'd2;
                    case (op)
                        8'hC3: begin pc = nn; cyc += 6; end
                        8'hCA: begin if (z) pc = nn; cyc += 6; end
                        8'hC2: begin if (!z) pc = nn; cyc += 6; end
                        8'h3A: begin a = ref_mem[nn]; cyc += 8; end
                        default: begin ref_mem[nn] = a; exp_q.push_back('{nn, a}); cyc += 7; end
                    endcase
                end
                default: cyc += 2;
            endcase
        end
        m_cyc = cyc; m_pc = pc; m_a = a; m_b = b; m_z = z; m_c = c;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 65536; i++) prog[i] = 8'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en = 1'b0;
        locked = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // mode 0: always ready; 1: random stalls; 2: three stall cycles on the write.
    task automatic drive_ready(input int mode);
        if (mode == 1) m_ready = ($urandom_range(0, 3) != 0);
        else if (mode == 2 && (o_wr || wcnt > 0) && wcnt < 5) begin
            if (wcnt > 0 && wcnt < 4) begin
                chk("stall_wr_held", o_wr, 1);
                chk("stall_addr", o_addr, 16'h8000);
                chk("stall_data", o_data, 8'h42);
            end
            if (wcnt == 4) chk("wr_dropped", o_wr, 0);
            m_ready = (wcnt >= 3);
            wcnt++;
        end else m_ready = 1'b1;
    endtask

    task automatic run(input int mode);
        do_reset();
        for (int i = 0; i < 65536; i++) ref_mem[i] = prog[i];
        model_run();
        act_cyc = 0; halted_seen = 1'b0; wcnt = 0;
        mon_en = 1'b1;
        locked = 1'b1;
        for (int cyc = 0; cyc < 4000 && !halted_seen; cyc++) begin
            drive_ready(mode);
            @(negedge clk);
        end
        #3;
        chk("halted", halted_seen, 1);
        chk("cycles", act_cyc, m_cyc);
        chk("halt_pc", o_addr, m_pc);
        chk("halt_wr", o_wr, 0);
        chk("reg_a", dut.r_a, m_a);
        chk("reg_b", dut.r_b, m_b);
        chk("flag_z", dut.r_z, m_z);
        chk("flag_c", dut.r_c, m_c);
        chk("pending_writes", exp_q.size(), 0);
        exp_q.delete();
        mon_en = 1'b0;
    endtask

    function automatic logic is_supported(logic [7:0] op);
        return op inside {8'h00, 8'h3C, 8'h78, 8'h47, 8'h3E, 8'h06, 8'hC6,
                          8'hC3, 8'hCA, 8'hC2, 8'h3A, 8'h32, 8'h76};
    endfunction

    task automatic gen_random();
        int          n, kind[20], len[20];
        logic [15:0] adr[21], p, t;
        logic [7:0]  op;
        n = $urandom_range(8, 20);
        p = 16'h0000;
        for (int i = 0; i < n; i++) begin
            kind[i] = $urandom_range(0, 13);
            len[i] = (kind[i] inside {4, 5, 6, 13}) ? 2 : (kind[i] >= 7 && kind[i] <= 11) ? 3 : 1;
            adr[i] = p;
            p = p + 16'(len[i]);
        end
        adr[n] = p;
        for (int i = 0; i < n; i++) begin
            p = adr[i];
            case (kind[i])
                0: prog[p] = 8'h00;
                1: prog[p] = 8'h3C;
                2: prog[p] = 8'h78;
                3: prog[p] = 8'h47;
                4: prog[p] = 8'h3E;
                5: prog[p] = 8'h06;
                6, 13: prog[p] = 8'hC6;
                7, 8, 9: begin
                    prog[p] = (kind[i] == 7) ? 8'hC3 : (kind[i] == 8) ? 8'hCA : 8'hC2;
                    t = adr[$urandom_range(i + 1, n)];
                    prog[p + 16'd1] = t[7:0];
                    prog[p + 16'd2] = t[15:8];
                end
                10, 11: begin
                    prog[p] = (kind[i] == 10) ? 8'h3A : 8'h32;
                    prog[p + 16'd1] = 8'($urandom_range(0, 255));
                    prog[p + 16'd2] = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h90;
                    if (kind[i] == 11) prog[p + 16'd2] = 8'h80;
                end
                default: begin
                    do op = 8'($urandom); while (is_supported(op));
                    prog[p] = op;
                end
            endcase
        end
        p = adr[n];
        prog[p] = 8'h32; prog[p + 16'd1] = 8'($urandom); prog[p + 16'd2] = 8'h80;
        prog[p + 16'd3] = 8'h76;
    endtask

    initial begin
        locked = 1'b0; m_ready = 1'b1; mon_en = 1'b0;
        act_cyc = 0; wcnt = 0; halted_seen = 1'b0;

        fill_mem();
        do_reset();
        #3;
        chk("rst_addr", o_addr, 16'h0000);
        chk("rst_wr", o_wr, 0);
        chk("rst_data", o_data, 8'h00);
        chk("rst_pc", dut.r_pc, 16'h0000);

        fill_mem();
        {prog[0], prog[1], prog[2], prog[3], prog[4]} = {8'h3E, 8'h05, 8'hC6, 8'hFB, 8'h76};
        run(0);
        chk("add_cycles", act_cyc, 10);
        chk("add_a", dut.r_a, 8'h00);
        chk("add_zc", {dut.r_z, dut.r_c}, 2'b11);

        fill_mem();
        {prog[0], prog[1], prog[2], prog[3], prog[4], prog[5]} = {8'h3E, 8'h42, 8'h32, 8'h00, 8'h80, 8'h76};
        run(0);
        chk("st_cycles", act_cyc, 13);

        run(2);

        fill_mem();
        {prog[0], prog[1], prog[2], prog[3], prog[4]} = {8'h3A, 8'h00, 8'h90, 8'h47, 8'h76};
        prog[16'h9000] = 8'hA5;
        run(0);
        chk("ldm_ab", {dut.r_a, dut.r_b}, 16'hA5A5);

        fill_mem();
        {prog[0], prog[1], prog[2]} = {8'hC3, 8'h10, 8'h00};
        prog[16'h0010] = 8'h76;
        run(0);
        chk("jp_fetch_addr", trace[6], 16'h0010);
        chk("jp_halt_pc", o_addr, 16'h0011);

        // PC wraps FFFF->0000; INC A sets Z, which then steers JP Z.
        fill_mem();
        {prog[0], prog[1], prog[2]} = {8'hCA, 8'h10, 8'h00};
        {prog[3], prog[4], prog[5]} = {8'hC3, 8'hFD, 8'hFF};
        {prog[16'hFFFD], prog[16'hFFFE], prog[16'hFFFF]} = {8'h3E, 8'hFF, 8'h3C};
        {prog[16'h10], prog[16'h11], prog[16'h12], prog[16'h13]} = {8'h32, 8'h00, 8'h80, 8'h76};
        run(1);

        fill_mem();
        {prog[0], prog[1], prog[2], prog[3]} = {8'h3A, 8'h00, 8'h90, 8'h76};
        prog[16'h9000] = 8'hA5;
        do_reset();
        act_cyc = 0; halted_seen = 1'b0;
        mon_en = 1'b1; locked = 1'b1; m_ready = 1'b1;
        repeat (5) @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
        #3;
        chk("abort_addr", o_addr, 16'h0000);
        chk("abort_a", dut.r_a, 8'h00);
        chk("abort_wr", o_wr, 0);
        repeat (2) @(negedge clk);
        #3;
        chk("abort_refetch", o_addr, 16'h0001);
        mon_en = 1'b0;

        for (int t = 0; t < 16; t++) begin
            fill_mem();
            gen_random();
            run((t % 2 == 0) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
